// File: rtl/cmp_share_arbiter_if.sv
// Request/response bundle for the shared comparator arbiter.
//   req0_*   : port 0 requester (branch/SLT path) - valid/ready, operands, unsigned flag
//   req1_*   : port 1 requester (encryption accelerator) - same fields as port 0
//   rsp_*    : tagged result channel - valid/ready, id, greater/equal/less flags
// Modports: slave = arbiter side, master = requester/consumer side.
interface cmp_share_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  req0_valid;
  logic                  req0_ready;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;
  logic                  req0_unsigned;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;
  logic                  req1_unsigned;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic                  rsp_greater;
  logic                  rsp_equal;
  logic                  rsp_less;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_unsigned,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_unsigned,
    output req1_ready,
    input  rsp_ready,
    output rsp_valid, rsp_id, rsp_greater, rsp_equal, rsp_less
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_unsigned,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_unsigned,
    input  req1_ready,
    output rsp_ready,
    input  rsp_valid, rsp_id, rsp_greater, rsp_equal, rsp_less
  );

endinterface

// File: rtl/cmp_share_arbiter.sv
// Round-robin time-share of one signed magnitude comparator between two requesters.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : cmp_share_arbiter_if.slave - two request ports and the tagged response
// Flow per compare: IDLE (accept one request) -> CMP (compare latched operands)
// -> RESP (hold result until consumed). Minimum three cycles per compare.
module cmp_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cmp_share_arbiter_if.slave    bus
);

  localparam int unsigned LOW_W = DATA_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched request and arbitration history
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  uns_q;
  logic                  id_q;
  logic                  last_grant_q;

  // Registered response
  logic rsp_valid_q;
  logic rsp_id_q;
  logic rsp_greater_q, rsp_equal_q, rsp_less_q;

  // Combinational control
  logic grant_c;
  logic any_valid_c;
  logic take_c;
  logic load_rsp_c;
  logic clear_rsp_c;
  logic ready0_c, ready1_c;

  // Winning port's request fields
  logic [DATA_WIDTH-1:0] sel_a_c, sel_b_c;
  logic                  sel_uns_c;

  // Comparator
  logic [DATA_WIDTH-1:0] flip_c, cmp_a_c, cmp_b_c;
  logic                  gt_c, eq_c, lt_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arbitration, next state and handshake strobes
  always_comb begin
    state_d     = state_q;
    any_valid_c = bus.req0_valid | bus.req1_valid;
    take_c      = 1'b0;
    load_rsp_c  = 1'b0;
    clear_rsp_c = 1'b0;
    ready0_c    = 1'b0;
    ready1_c    = 1'b0;

    // Contention goes to the port that did not win last time
    if (bus.req0_valid && bus.req1_valid) begin
      grant_c = ~last_grant_q;
    end else begin
      grant_c = bus.req1_valid;
    end

    unique case (state_q)
      IDLE: begin
        if (any_valid_c) begin
          ready0_c = ~grant_c;
          ready1_c = grant_c;
          take_c   = 1'b1;
          state_d  = CMP;
        end
      end
      CMP: begin
        load_rsp_c = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          clear_rsp_c = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mux the granted port's fields toward the capture registers
  always_comb begin
    sel_a_c   = grant_c ? bus.req1_a        : bus.req0_a;
    sel_b_c   = grant_c ? bus.req1_b        : bus.req0_b;
    sel_uns_c = grant_c ? bus.req1_unsigned : bus.req0_unsigned;
  end

  // Unsigned operands become signed-comparable by inverting the MSB of both
  always_comb begin
    flip_c  = {uns_q, LOW_W'(0)};
    cmp_a_c = a_q ^ flip_c;
    cmp_b_c = b_q ^ flip_c;
    gt_c    = $signed(cmp_a_c) > $signed(cmp_b_c);
    eq_c    = cmp_a_c == cmp_b_c;
    lt_c    = ~gt_c & ~eq_c;
  end

  // Request capture and round-robin history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      uns_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (take_c) begin
      a_q          <= sel_a_c;
      b_q          <= sel_b_c;
      uns_q        <= sel_uns_c;
      id_q         <= grant_c;
      last_grant_q <= grant_c;
    end
  end

  // Response registers: loaded at the end of CMP, held until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_greater_q <= 1'b0;
      rsp_equal_q   <= 1'b0;
      rsp_less_q    <= 1'b0;
    end else if (load_rsp_c) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= id_q;
      rsp_greater_q <= gt_c;
      rsp_equal_q   <= eq_c;
      rsp_less_q    <= lt_c;
    end else if (clear_rsp_c) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  // Readies are held low while reset is asserted
  assign bus.req0_ready  = ready0_c & rst_n;
  assign bus.req1_ready  = ready1_c & rst_n;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_greater = rsp_greater_q;
  assign bus.rsp_equal   = rsp_equal_q;
  assign bus.rsp_less    = rsp_less_q;

  // A valid response carries exactly one flag
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid_q |-> $onehot({rsp_greater_q, rsp_equal_q, rsp_less_q}));

  // A stalled response holds its payload
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid_q && !bus.rsp_ready) |=> (rsp_valid_q && $stable(rsp_id_q)
      && $stable({rsp_greater_q, rsp_equal_q, rsp_less_q})));

endmodule
